slon5_scan_m: RTL and testbench
===============================

SLON5_SCAN_M -- requirements
Module: slon5_scan_m

Purpose: display scan sequencer directly upstream of the slon5 table stage. It walks the digit index that feeds the stage's sw input, captures the returned table element and drives a multiplexed digit/segment display with dead time.

Interface
Parameters
REQ-001 SHALL have parameter DIGITS, default 4: number of display digits scanned (2..16).
REQ-002 SHALL have parameter DIV, default 1000: clk cycles each digit is shown (>=1).
REQ-003 SHALL have parameter BLANK, default 2: dead-time clk cycles before each digit (>=1).
REQ-004 SHALL have parameter DOUT_W, default `DOUT_WIDTH: width of the table element and of the segment bus.
REQ-005 SHALL have parameter IDX_W, default $clog2(DIGITS): width of the digit index.
REQ-006 SHALL have parameter DIG_POL, default 1: digit-enable active level; 1 = active-high, 0 = active-low.

Ports
REQ-007 SHALL have clk, input, 1: the single clock; all logic on its rising edge.
REQ-008 SHALL have rst, input, 1: reset, synchronous and active-high.
REQ-009 SHALL have en, input, 1: scan enable.
REQ-010 SHALL have idx_o, output, IDX_W: digit index driven to the table stage sw input.
REQ-011 SHALL have dout_i, input, DOUT_W: table element returned combinationally for idx_o.
REQ-012 SHALL have seg_o, output, DOUT_W: registered segment pattern.
REQ-013 SHALL have dig_o, output, DIGITS: one-hot digit enable at level DIG_POL.
REQ-014 SHALL have frame_o, output, 1: one-cycle pulse at each index wrap.

Function
REQ-015 SHALL implement a two-state FSM, BLK and SHOW, with a cycle counter cnt that restarts at 0 on every state entry.
REQ-016 BLK: dig_o SHALL be all-inactive. cnt SHALL increment each cycle. When cnt==BLANK-1, the block SHALL register seg_o<=dout_i and go to SHOW on the same edge.
REQ-017 SHOW: dig_o bit idx_o SHALL be active and all other bits inactive. cnt SHALL increment each cycle. When cnt==DIV-1, the block SHALL go to BLK and advance idx_o.
REQ-018 Index advance SHALL be idx_o<=idx_o+1. When idx_o==DIGITS-1 it SHALL wrap to 0, and frame_o SHALL be 1 for exactly the one cycle following that edge.
REQ-019 idx_o SHALL be stable throughout BLK and SHOW of a digit. dout_i therefore has BLANK cycles to settle, and zero-cycle table latency is sufficient.
REQ-020 One digit period SHALL be exactly BLANK+DIV cycles; one frame SHALL be DIGITS*(BLANK+DIV) cycles.
REQ-021 seg_o SHALL change only on the BLK->SHOW edge, so seg_o never changes while any digit is active.
REQ-022 en=0 SHALL, on the next edge, force state BLK with cnt=0, hold idx_o and seg_o, and force frame_o=0.
REQ-023 When en returns to 1, the block SHALL run a full BLANK phase for the held idx_o and SHALL NOT skip or repeat indices.
REQ-024 When en falls on the same edge as a wrap, en SHALL take priority: no advance and no frame_o pulse.
REQ-025 The counter width SHALL be $clog2(max(DIV,BLANK)+1). There SHALL be no overflow for any legal parameter set.
REQ-026 When DIGITS is not a power of two, idx_o SHALL never take a value >= DIGITS.

Reset
REQ-027 rst=1 SHALL, on the next edge, set state BLK, cnt=0, idx_o=0, seg_o=0, frame_o=0, and dig_o all-inactive (all 0 for DIG_POL=1, all 1 for DIG_POL=0).
REQ-028 rst SHALL override en and any in-progress state, including mid-SHOW and the wrap cycle.
REQ-029 After rst falls with en=1, the first digit SHALL become active exactly BLANK cycles later.

Verification
Benches use DIGITS=4, DIV=4, BLANK=2, DOUT_W=8, DIG_POL=1, and a table model returning dout_i=8'hA0+idx_o.
REQ-030 Scenario: release rst, en=1 -> dig_o=0 for 2 cycles; then dig_o=4'b0001 and seg_o=8'hA0 for 4 cycles; then 2 blank cycles; then 4'b0010 with 8'hA1; each digit period is 6 cycles.
REQ-031 Scenario: run 24 cycles from reset release -> frame_o is high exactly once, on the cycle after idx_o goes 3->0; the next pulse comes 24 cycles later.
REQ-032 Scenario: en=0 for 5 cycles mid-SHOW of idx 2 -> dig_o=0, idx_o stays 2, seg_o stays 8'hA2; after en=1: 2 blank cycles, then 4'b0100 again for 4 full cycles.
REQ-033 Scenario: assert rst during SHOW of idx 3 on the wrap cycle -> next cycle idx_o=0, seg_o=0, dig_o=0, frame_o=0; no pulse.
REQ-034 Scenario: DIG_POL=0 rerun of REQ-030 -> dig_o=4'b1111 in blank and 4'b1110 for digit 0.
REQ-035 Scenario: DIGITS=3 for 3 frames -> idx_o sequence 0,1,2,0,... with no value 3, and frame_o period 18 cycles.

Source files
------------

// File: rtl/slon5_scan_m.sv
// slon5_scan_m: display scan sequencer walking the table index and driving multiplexed digits with dead time
`ifndef DOUT_WIDTH
`define DOUT_WIDTH 8
`endif
module slon5_scan_m #(
  parameter int DIGITS  = 4,
  parameter int DIV     = 1000,
  parameter int BLANK   = 2,
  parameter int DOUT_W  = `DOUT_WIDTH,
  parameter int IDX_W   = $clog2(DIGITS),
  parameter int DIG_POL = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [IDX_W-1:0]  idx_o,
  input  logic [DOUT_W-1:0] dout_i,
  output logic [DOUT_W-1:0] seg_o,
  output logic [DIGITS-1:0] dig_o,
  output logic              frame_o
);
  localparam int MX = DIV > BLANK ? DIV : BLANK;
  localparam int CW = $clog2(MX + 1);
  localparam logic [DIGITS-1:0] OFF = {DIGITS{DIG_POL == 0}};
  typedef enum logic {BLK, SHOW} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DOUT_W-1:0] seg_q, seg_d;
  logic [DIGITS-1:0] dig_q, dig_d;
  logic frame_q, frame_d, last, wrap;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    idx_d   = idx_q;
    seg_d   = seg_q;
    frame_d = 1'b0;
    last    = state_q == BLK ? cnt_q == CW'(BLANK - 1) : cnt_q == CW'(DIV - 1);
    wrap    = idx_q == IDX_W'(DIGITS - 1);
    if (!en) begin
      state_d = BLK;
      cnt_d   = '0;
    end else if (last) begin
      cnt_d = '0;
      if (state_q == BLK) begin
        state_d = SHOW;
        seg_d   = dout_i;
      end else begin
        state_d = BLK;
        idx_d   = wrap ? '0 : idx_q + 1'b1;
        frame_d = wrap;
      end
    end
    dig_d = state_d == SHOW ? OFF ^ (DIGITS'(1) << idx_d) : OFF;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLK;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      dig_q   <= OFF;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
    end
  end
  assign idx_o   = idx_q;
  assign seg_o   = seg_q;
  assign dig_o   = dig_q;
  assign frame_o = frame_q;
endmodule

// File: tb/tb_slon5_scan_m.sv
// tb_slon5_scan_m: directed bench for slon5_scan_m across active-high, active-low and 3-digit builds
module tb_slon5_scan_m;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [1:0] idx_a, idx_b, idx_c;
  logic [7:0] dout_a, dout_b, dout_c, seg_a, seg_b, seg_c;
  logic [3:0] dig_a, dig_b;
  logic [2:0] dig_c;
  logic frame_a, frame_b, frame_c;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign dout_a = 8'hA0 + 8'(idx_a);
  assign dout_b = 8'hA0 + 8'(idx_b);
  assign dout_c = 8'hA0 + 8'(idx_c);
  slon5_scan_m #(.DIGITS(4), .DIV(4), .BLANK(2), .DOUT_W(8), .DIG_POL(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .idx_o(idx_a), .dout_i(dout_a),
    .seg_o(seg_a), .dig_o(dig_a), .frame_o(frame_a));
  slon5_scan_m #(.DIGITS(4), .DIV(4), .BLANK(2), .DOUT_W(8), .DIG_POL(0)) u_b (
    .clk(clk), .rst(rst), .en(en), .idx_o(idx_b), .dout_i(dout_b),
    .seg_o(seg_b), .dig_o(dig_b), .frame_o(frame_b));
  slon5_scan_m #(.DIGITS(3), .DIV(4), .BLANK(2), .DOUT_W(8), .DIG_POL(1)) u_c (
    .clk(clk), .rst(rst), .en(en), .idx_o(idx_c), .dout_i(dout_c),
    .seg_o(seg_c), .dig_o(dig_c), .frame_o(frame_c));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int d4, d3;
    logic sh;
    logic [7:0] sa, sc;
    step();
    step();
    chk("rst_idx", 32'(idx_a), 0);
    chk("rst_seg", 32'(seg_a), 0);
    chk("rst_dig", 32'(dig_a), 0);
    chk("rst_frame", 32'(frame_a), 0);
    chk("rst_dig_lo", 32'(dig_b), 32'hF);
    chk("rst_idx3", 32'(idx_c), 0);
    rst = 1'b0;
    sa = 8'h00;
    sc = 8'h00;
    for (int k = 1; k <= 54; k++) begin
      step();
      d4 = (k / 6) % 4;
      d3 = (k / 6) % 3;
      sh = (k % 6) >= 2;
      if (sh) begin
        sa = 8'hA0 + 8'(d4);
        sc = 8'hA0 + 8'(d3);
      end
      chk("run_idx", 32'(idx_a), 32'(d4));
      chk("run_dig", 32'(dig_a), sh ? 32'(1 << d4) : 0);
      chk("run_seg", 32'(seg_a), 32'(sa));
      chk("run_frame", 32'(frame_a), 32'((k % 24) == 0));
      chk("lo_dig", 32'(dig_b), sh ? 32'(4'hF ^ 4'(1 << d4)) : 32'hF);
      chk("lo_seg", 32'(seg_b), 32'(sa));
      chk("d3_idx", 32'(idx_c), 32'(d3));
      chk("d3_dig", 32'(dig_c), sh ? 32'(1 << d3) : 0);
      chk("d3_seg", 32'(seg_c), 32'(sc));
      chk("d3_frame", 32'(frame_c), 32'((k % 18) == 0));
    end
    for (int k = 55; k <= 63; k++) step();
    chk("pre_hold_idx", 32'(idx_a), 2);
    chk("pre_hold_dig", 32'(dig_a), 32'b0100);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("hold_dig", 32'(dig_a), 0);
      chk("hold_idx", 32'(idx_a), 2);
      chk("hold_seg", 32'(seg_a), 32'hA2);
      chk("hold_frame", 32'(frame_a), 0);
    end
    en = 1'b1;
    step();
    chk("resume_blank", 32'(dig_a), 0);
    chk("resume_blank_idx", 32'(idx_a), 2);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("resume_dig", 32'(dig_a), 32'b0100);
      chk("resume_seg", 32'(seg_a), 32'hA2);
    end
    step();
    chk("next_idx", 32'(idx_a), 3);
    chk("next_dig", 32'(dig_a), 0);
    for (int k = 0; k < 5; k++) step();
    chk("wrapcyc_idx", 32'(idx_a), 3);
    chk("wrapcyc_dig", 32'(dig_a), 32'b1000);
    chk("wrapcyc_seg", 32'(seg_a), 32'hA3);
    rst = 1'b1;
    step();
    chk("rstwrap_idx", 32'(idx_a), 0);
    chk("rstwrap_seg", 32'(seg_a), 0);
    chk("rstwrap_dig", 32'(dig_a), 0);
    chk("rstwrap_frame", 32'(frame_a), 0);
    chk("rstwrap_dig_lo", 32'(dig_b), 32'hF);
    rst = 1'b0;
    step();
    chk("rstwrap_frame2", 32'(frame_a), 0);
    chk("rstwrap_dig2", 32'(dig_a), 0);
    for (int k = 2; k <= 23; k++) step();
    chk("enwrap_pre_idx", 32'(idx_a), 3);
    chk("enwrap_pre_dig", 32'(dig_a), 32'b1000);
    en = 1'b0;
    step();
    chk("enwrap_idx", 32'(idx_a), 3);
    chk("enwrap_frame", 32'(frame_a), 0);
    chk("enwrap_dig", 32'(dig_a), 0);
    chk("enwrap_seg", 32'(seg_a), 32'hA3);
    en = 1'b1;
    step();
    step();
    chk("enwrap_resume_dig", 32'(dig_a), 32'b1000);
    chk("enwrap_resume_idx", 32'(idx_a), 3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
